// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Two-master arbiter and access sequencer for the single data-memory port.
// The CPU memory stage and a DMA/debug master share one memory bus. Accesses
// are serialised. Each access runs a variable-latency ready handshake. The
// CPU is held in a stall until its own access completes. A starvation counter
// bounds how long a waiting DMA request can lose to the CPU. A wait counter
// bounds how long an access can hang waiting for memory.
//
// Ports
//   clk_i, reset_ni         clock; asynchronous active-low reset
//   cpu_req_i/wr/addr/
//     wdata/be              CPU access request, held while cpu_stall_o=1
//   cpu_stall_o             pipeline hold (combinational)
//   cpu_rdata_o             CPU read data, non-zero only in the completion cycle
//   cpu_err_o               pulse: CPU access aborted by timeout
//   dma_req_i/wr/addr/
//     wdata/be              DMA access request, held until dma_gnt_o
//   dma_gnt_o               pulse: DMA request latched (IDLE cycle)
//   dma_done_o              pulse: DMA access finished (cycle after ready/abort)
//   dma_rdata_o             registered DMA read data
//   dma_err_o               pulse with dma_done_o when the access timed out
//   mem_req_o/wr/addr/
//     wdata/be              registered memory request, stable while mem_req_o=1
//   mem_ready_i, mem_rdata_i memory completion handshake and read data
module dmem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        cpu_req_i,
  input  logic        cpu_wr_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_wdata_i,
  input  logic [3:0]  cpu_be_i,
  output logic        cpu_stall_o,
  output logic [31:0] cpu_rdata_o,
  output logic        cpu_err_o,
  input  logic        dma_req_i,
  input  logic        dma_wr_i,
  input  logic [31:0] dma_addr_i,
  input  logic [31:0] dma_wdata_i,
  input  logic [3:0]  dma_be_i,
  output logic        dma_gnt_o,
  output logic        dma_done_o,
  output logic [31:0] dma_rdata_o,
  output logic        dma_err_o,
  output logic        mem_req_o,
  output logic        mem_wr_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_be_o,
  input  logic        mem_ready_i,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CPU_BUSY = 2'd1,
    DMA_BUSY = 2'd2
  } state_e;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [7:0] WAIT_LAST  = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_wr_q, mem_wr_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic        dma_done_q, dma_done_d;
  logic        dma_err_q, dma_err_d;
  logic [31:0] dma_rdata_q, dma_rdata_d;

  logic busy;
  logic timeout;
  logic dma_win;
  logic cpu_win;

  // An access aborts in the cycle the wait counter reaches its last value
  // without ready; with TIMEOUT=N the request is therefore visible N cycles.
  assign busy    = (state_q != IDLE);
  assign timeout = busy && !mem_ready_i && (wait_cnt_q == WAIT_LAST);

  // DMA takes the bus when the CPU is quiet, or when it has already lost
  // STARVE_LIMIT consecutive arbitrations to the CPU.
  assign dma_win = (state_q == IDLE) && dma_req_i &&
                   (!cpu_req_i || (starve_cnt_q == STARVE_MAX));
  assign cpu_win = (state_q == IDLE) && !dma_win && cpu_req_i;

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    mem_req_d    = mem_req_q;
    mem_wr_d     = mem_wr_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_be_d     = mem_be_q;
    dma_done_d   = 1'b0;
    dma_err_d    = 1'b0;
    dma_rdata_d  = dma_rdata_q;

    case (state_q)
      IDLE: begin
        if (dma_win) begin
          state_d     = DMA_BUSY;
          mem_req_d   = 1'b1;
          mem_wr_d    = dma_wr_i;
          mem_addr_d  = dma_addr_i;
          mem_wdata_d = dma_wdata_i;
          mem_be_d    = dma_be_i;
          wait_cnt_d  = 8'd0;
        end else if (cpu_win) begin
          state_d     = CPU_BUSY;
          mem_req_d   = 1'b1;
          mem_wr_d    = cpu_wr_i;
          mem_addr_d  = cpu_addr_i;
          mem_wdata_d = cpu_wdata_i;
          mem_be_d    = cpu_be_i;
          wait_cnt_d  = 8'd0;
        end
      end
      CPU_BUSY, DMA_BUSY: begin
        if (mem_ready_i || timeout) begin
          // Completion or abort: always return through IDLE, so no two bus
          // cycles are ever back to back.
          state_d   = IDLE;
          mem_req_d = 1'b0;
          if (state_q == DMA_BUSY) begin
            dma_done_d = 1'b1;
            dma_err_d  = timeout;
            if (mem_ready_i && !mem_wr_q) begin
              dma_rdata_d = mem_rdata_i;
            end
          end
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase

    // Starvation count: only meaningful while a DMA request is waiting.
    if (!dma_req_i || dma_win) begin
      starve_cnt_d = 4'd0;
    end else if (cpu_win && (starve_cnt_q < STARVE_MAX)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q      <= IDLE;
      starve_cnt_q <= 4'd0;
      wait_cnt_q   <= 8'd0;
      mem_req_q    <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_addr_q   <= 32'd0;
      mem_wdata_q  <= 32'd0;
      mem_be_q     <= 4'd0;
      dma_done_q   <= 1'b0;
      dma_err_q    <= 1'b0;
      dma_rdata_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      mem_req_q    <= mem_req_d;
      mem_wr_q     <= mem_wr_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_be_q     <= mem_be_d;
      dma_done_q   <= dma_done_d;
      dma_err_q    <= dma_err_d;
      dma_rdata_q  <= dma_rdata_d;
    end
  end

  // CPU side is combinational so the pipeline advances in the very cycle
  // the memory answers (or the access is abandoned).
  assign cpu_stall_o = cpu_req_i &
                       ~((state_q == CPU_BUSY) & (mem_ready_i | timeout));
  assign cpu_rdata_o = ((state_q == CPU_BUSY) && mem_ready_i) ? mem_rdata_i : 32'd0;
  assign cpu_err_o   = (state_q == CPU_BUSY) && timeout;

  assign dma_gnt_o   = dma_win;
  assign dma_done_o  = dma_done_q;
  assign dma_err_o   = dma_err_q;
  assign dma_rdata_o = dma_rdata_q;

  assign mem_req_o   = mem_req_q;
  assign mem_wr_o    = mem_wr_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_be_o    = mem_be_q;

endmodule
